// File: rtl/asic_scan_regbank_if.sv
// ----------------------------------------------------------------------------
// asic_scan_regbank_if
//
// Bundles the functional, scan and shift-tracker signals of asic_scan_regbank.
// Clock and reset stay as plain ports on the module.
//
// Parameters
//   N       total register width
//   CHAINS  number of scan chains (chain length L = N/CHAINS)
//
// Signals
//   d          [N]       functional data
//   en         [1]       functional load enable
//   se         [1]       scan enable (shift mode)
//   si         [CHAINS]  scan in, one bit per chain
//   q          [N]       register contents
//   so         [CHAINS]  scan out, one bit per chain
//   shift_cnt  [CW]      consecutive-shift count, CW = $clog2(L)
//   shift_done [1]       one-cycle pulse after L consecutive shifts
//
// Modports
//   master  drives d/en/se/si, observes the outputs (test controller, bench)
//   slave   the register bank itself
// ----------------------------------------------------------------------------
interface asic_scan_regbank_if #(
    parameter int N      = 16,
    parameter int CHAINS = 2
);
    localparam int L  = N / CHAINS;
    localparam int CW = $clog2(L);

    logic [N-1:0]      d;
    logic              en;
    logic              se;
    logic [CHAINS-1:0] si;
    logic [N-1:0]      q;
    logic [CHAINS-1:0] so;
    logic [CW-1:0]     shift_cnt;
    logic              shift_done;

    modport master (
        output d, en, se, si,
        input  q, so, shift_cnt, shift_done
    );

    modport slave (
        input  d, en, se, si,
        output q, so, shift_cnt, shift_done
    );
endinterface

// File: rtl/asic_scan_regbank.sv
// ----------------------------------------------------------------------------
// asic_scan_regbank
//
// Parametrised bank of positive-edge D flops with mux-scan. The N bits are cut
// into CHAINS independent scan chains of length L = N/CHAINS. Chain c owns
// q[c*L +: L]; si[c] enters at bit c*L, data moves toward the MSB and so[c] is
// the chain's top bit q[c*L+L-1]. A shift-progress tracker counts consecutive
// shift cycles and pulses shift_done when a full chain has been unloaded.
//
// Per posedge the priority is: scan shift (se) > functional load (en) > hold.
// nreset clears every flop asynchronously and overrides everything else.
//
// Parameters
//   N       total register width, multiple of CHAINS
//   CHAINS  number of scan chains, chain length L = N/CHAINS must be >= 2
//   PROP    implementation property string, passed through to cells
//
// Ports
//   clk     clock, all functional state updates on posedge
//   nreset  asynchronous active-low reset
//   bus     asic_scan_regbank_if.slave: d, en, se, si in; q, so, shift_cnt,
//           shift_done out
//
// Configuration macro ASIC_SCAN_LOCKUP_EN
//   defined   : so[c] comes from a negedge lockup flop per chain, giving half a
//               cycle of hold margin toward the next scan segment.
//   undefined : so[c] is the chain's top q bit directly; no negedge logic.
// ----------------------------------------------------------------------------
module asic_scan_regbank #(
    parameter int    N      = 16,
    parameter int    CHAINS = 2,
    parameter string PROP   = "DEFAULT"
) (
    input  logic               clk,
    input  logic               nreset,
    asic_scan_regbank_if.slave bus
);
    localparam int L  = N / CHAINS;
    localparam int CW = $clog2(L);

    // Reject geometries the chain slicing cannot represent.
    if ((N % CHAINS) != 0 || L < 2 || PROP == "") begin : g_bad_cfg
        $error("asic_scan_regbank: N must be a multiple of CHAINS with N/CHAINS >= 2");
    end

    logic [N-1:0]      q_r;
    logic [N-1:0]      q_nxt;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt;
    logic              done_r;
    logic              done_nxt;
    logic [CHAINS-1:0] tail;

    // ------------------------------------------------------------------
    // Data path next value: shift, load or hold.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaulting to the held value first means every path assigns
        // q_nxt, so no latch is inferred for the implicit hold case.
        q_nxt = q_r;
        if (bus.se) begin
            for (int c = 0; c < CHAINS; c++) begin
                q_nxt[c*L +: L] = {q_r[c*L +: L-1], bus.si[c]};
            end
        end else if (bus.en) begin
            q_nxt = bus.d;
        end
    end

    // ------------------------------------------------------------------
    // Shift tracker next state. Any non-shift edge discards a partial count,
    // so only an unbroken run of L shifts produces a pulse.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_nxt  = '0;
        done_nxt = 1'b0;
        if (bus.se) begin
            if (cnt_r == CW'(L - 1)) begin
                done_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_r + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!nreset) begin
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all registered, no path from inputs.
    // ------------------------------------------------------------------
    always_comb begin
        tail = '0;
        for (int c = 0; c < CHAINS; c++) begin
            tail[c] = q_r[c*L + L - 1];
        end
    end

`ifdef ASIC_SCAN_LOCKUP_EN
    // Lockup flops: re-time each chain tail onto the falling edge so the next
    // segment sees so change half a cycle after q.
    logic [CHAINS-1:0] so_r;

    always_ff @(negedge clk or negedge nreset) begin
        if (!nreset) begin
            so_r <= '0;
        end else begin
            so_r <= tail;
        end
    end

    assign bus.so = so_r;
`else
    assign bus.so = tail;
`endif

    assign bus.q          = q_r;
    assign bus.shift_cnt  = cnt_r;
    assign bus.shift_done = done_r;

endmodule

// File: tb/tb_asic_scan_regbank.sv
// ----------------------------------------------------------------------------
// tb_asic_scan_regbank
//
// Self-checking bench for asic_scan_regbank at N=8, CHAINS=2 (L=4). Each
// scenario task pushes the expected q/shift_cnt/shift_done for an edge onto a
// scoreboard queue while driving stimulus, then pops and compares once the
// DUT has clocked. Scan-out values are compared inline just before the edge.
// Inputs change and outputs are sampled 1 time unit after a clock edge.
// ----------------------------------------------------------------------------
module tb_asic_scan_regbank;
    localparam int N      = 8;
    localparam int CHAINS = 2;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic [1:0] cnt;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    asic_scan_regbank_if #(.N(N), .CHAINS(CHAINS)) bus ();

    asic_scan_regbank #(
        .N      (N),
        .CHAINS (CHAINS),
        .PROP   ("DEFAULT")
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string tag, input logic [7:0] q,
                                input logic [1:0] cnt, input logic done);
        exp_t e;
        e.tag  = tag;
        e.q    = q;
        e.cnt  = cnt;
        e.done = done;
        return e;
    endfunction

    // Reference shift for L=4: chain1 = q[7:4], chain0 = q[3:0], toward MSB.
    function automatic logic [7:0] mshift(input logic [7:0] q, input logic [1:0] si);
        return {q[6:4], si[1], q[2:0], si[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic se, input logic en, input logic [7:0] d,
                         input logic [1:0] si);
        bus.se = se;
        bus.en = en;
        bus.d  = d;
        bus.si = si;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        drive(1'b0, 1'b1, 8'hFF, 2'b11);
        nreset = 1'b0;
        // Reset held across edges with a load pending: must stay clear.
        sb.push_back(mk("reset_hold", 8'h00, 2'd0, 1'b0));
        tick();
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end

        @(negedge clk);
        nreset = 1'b1;
        drive(1'b0, 1'b1, 8'h3C, 2'b00);
        sb.push_back(mk("load_3c", 8'h3C, 2'd0, 1'b0));
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end

        // Drop reset between edges: outputs clear with no clock edge.
        #2;
        nreset = 1'b0;
        sb.push_back(mk("async_clear", 8'h00, 2'd0, 1'b0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end
        n_cmp++;
        if (bus.so !== 2'b00) begin
            n_bad++;
            $display("FAIL async_clear_so: got so=%b, want so=00", bus.so);
        end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_hold();
        exp_t       e;
        logic       en_t [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] d_t  [3] = '{8'hA5, 8'hFF, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, en_t[i], d_t[i], 2'b11);
            sb.push_back(mk($sformatf("load_hold%0d", i), 8'hA5, 2'd0, 1'b0));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
                n_bad++;
                $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                         e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Unload 8'hA5 with zeros shifted in.
    task automatic test_shift_unload();
        exp_t       e;
        logic [1:0] so_t  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [7:0] q_t   [4] = '{8'h4A, 8'h84, 8'h08, 8'h00};
        logic [1:0] cnt_t [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       dn_t  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b0, 8'hFF, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.so !== so_t[k]) begin
                n_bad++;
                $display("FAIL unload_so%0d: got so=%b, want so=%b", k, bus.so, so_t[k]);
            end
            sb.push_back(mk($sformatf("unload%0d", k), q_t[k], cnt_t[k], dn_t[k]));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
                n_bad++;
                $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                         e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
            end
        end
        drive(1'b0, 1'b0, 8'hFF, 2'b00);
        sb.push_back(mk("unload_idle", 8'h00, 2'd0, 1'b0));
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end
    endtask

    // ------------------------------------------------------------------
    // se beats en: from q=0, one edge with si=11 must give 8'h11, not d.
    task automatic test_priority();
        exp_t e;
        drive(1'b1, 1'b1, 8'hFF, 2'b11);
        sb.push_back(mk("prio_shift", 8'h11, 2'd1, 1'b0));
        tick();
        drive(1'b0, 1'b0, 8'hFF, 2'b00);
        sb.push_back(mk("prio_hold", 8'h11, 2'd0, 1'b0));
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.tag == "prio_shift") begin
                // The first entry was due one edge ago; check it via the
                // value that must still be held now (en=0, se=0).
                if (bus.q !== e.q) begin
                    n_bad++;
                    $display("FAIL %s: got q=%h, want q=%h", e.tag, bus.q, e.q);
                end
            end else if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
                n_bad++;
                $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                         e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
            end
        end
    endtask

    // Same priority case checked on its own edge, with the counter.
    task automatic test_priority_edge();
        exp_t e;
        drive(1'b0, 1'b1, 8'h00, 2'b00);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 2'b11);
        sb.push_back(mk("prio_edge", 8'h11, 2'd1, 1'b0));
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Shift runs of 6, 2 and 4 separated by idle edges. Only unbroken runs
    // of 4 pulse shift_done; breaks discard the partial count.
    task automatic test_tracker();
        exp_t       e;
        logic [7:0] q_m = 8'h11;
        logic [1:0] si_v;
        logic       se_t  [15] = '{1,1,1,1,1,1,0, 1,1,0, 1,1,1,1,0};
        logic [1:0] cnt_t [15] = '{1,2,3,0,1,2,0, 1,2,0, 1,2,3,0,0};
        logic       dn_t  [15] = '{0,0,0,1,0,0,0, 0,0,0, 0,0,0,1,0};
        for (int i = 0; i < 15; i++) begin
            si_v = 2'($urandom_range(0, 3));
            drive(se_t[i], 1'b0, 8'hFF, si_v);
            if (se_t[i]) q_m = mshift(q_m, si_v);
            sb.push_back(mk($sformatf("tracker%0d", i), q_m, cnt_t[i], dn_t[i]));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
                n_bad++;
                $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                         e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Reset in the middle of a shift run; the next shift restarts at count 1.
    task automatic test_reset_mid_shift();
        exp_t e;
        drive(1'b1, 1'b0, 8'h00, 2'b11);
        tick();
        tick();
        #2;
        nreset = 1'b0;
        sb.push_back(mk("mid_shift_clear", 8'h00, 2'd0, 1'b0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end
        @(negedge clk);
        nreset = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 2'b01);
        sb.push_back(mk("mid_shift_restart", 8'h01, 2'd1, 1'b0));
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.q, bus.shift_cnt, bus.shift_done} !== {e.q, e.cnt, e.done}) begin
            n_bad++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                     e.tag, bus.q, bus.shift_cnt, bus.shift_done, e.q, e.cnt, e.done);
        end
    endtask

    // ------------------------------------------------------------------
    // so timing relative to q: straight through, or half a cycle later when
    // the lockup flops are built in. q is 8'h01 on entry (both tails 0).
    task automatic test_so_timing();
        drive(1'b0, 1'b1, 8'h80, 2'b00);
        tick();
`ifdef ASIC_SCAN_LOCKUP_EN
        n_cmp++;
        if (bus.so !== 2'b00) begin
            n_bad++;
            $display("FAIL so_before_negedge: got so=%b, want so=00", bus.so);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.so !== 2'b10) begin
            n_bad++;
            $display("FAIL so_after_negedge: got so=%b, want so=10", bus.so);
        end
`else
        n_cmp++;
        if (bus.so !== 2'b10) begin
            n_bad++;
            $display("FAIL so_follows_q: got so=%b, want so=10", bus.so);
        end
`endif
        drive(1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        test_reset();
        test_load_hold();
        test_shift_unload();
        test_priority();
        test_priority_edge();
        test_tracker();
        test_reset_mid_shift();
        test_so_timing();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
